// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard controller for a 5-stage MIPS pipeline: EX operand and
// store-data forwarding, a one-entry writeback history, load-use stalls, event counters.
module fwd_hazard_unit #(
    parameter int ADDR_W            = 5,
    parameter int DATA_W            = 32,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              forwarding,
    input  logic [ADDR_W-1:0] rs_id,
    input  logic [ADDR_W-1:0] rt_id,
    input  logic [ADDR_W-1:0] rs_ex,
    input  logic [ADDR_W-1:0] rt_ex,
    input  logic              mem_read_ex,
    input  logic              reg_write_ex,
    input  logic [ADDR_W-1:0] writereg_ex,
    input  logic              reg_write_exmem,
    input  logic [ADDR_W-1:0] writereg_exmem,
    input  logic              mem_write_exmem,
    input  logic [ADDR_W-1:0] rt_exmem,
    input  logic              reg_write_memwb,
    input  logic [ADDR_W-1:0] writereg_memwb,
    input  logic [DATA_W-1:0] wb_data_memwb,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              forwardSM,
    output logic [DATA_W-1:0] hist_data,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_ex,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  fwd_count
);

    typedef enum logic {IDLE, STALL} state_t;

    localparam logic [1:0] REM_INIT = 2'(LOAD_STALL_CYCLES - 1);

    state_t            state_q, state_d;
    logic [1:0]        rem_q, rem_d;
    logic              hist_valid_q, hist_valid_d;
    logic [ADDR_W-1:0] hist_reg_q, hist_reg_d;
    logic [DATA_W-1:0] hist_data_q, hist_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  fwd_cnt_q, fwd_cnt_d;

    logic [1:0] fwd_a, fwd_b;
    logic       fwd_sm;
    logic       load_hazard, interlock_hit, lu_stall, stall_raw, fwd_any;

    // Priority: EX/MEM (10) over MEM/WB (01) over history (11); r0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [ADDR_W-1:0] src,
        input logic              we_exmem,
        input logic [ADDR_W-1:0] dst_exmem,
        input logic              we_memwb,
        input logic [ADDR_W-1:0] dst_memwb,
        input logic              h_valid,
        input logic [ADDR_W-1:0] h_reg
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0) begin
            if (we_exmem && dst_exmem == src)      sel = 2'b10;
            else if (we_memwb && dst_memwb == src) sel = 2'b01;
            else if (h_valid && h_reg == src)      sel = 2'b11;
        end
        return sel;
    endfunction

    function automatic logic id_hit(
        input logic              we,
        input logic [ADDR_W-1:0] dst,
        input logic [ADDR_W-1:0] rs,
        input logic [ADDR_W-1:0] rt
    );
        return we && (dst != '0) && ((dst == rs) || (dst == rt));
    endfunction

    always_comb begin
        fwd_a  = 2'b00;
        fwd_b  = 2'b00;
        fwd_sm = 1'b0;
        if (forwarding) begin
            fwd_a  = fwd_sel(rs_ex, reg_write_exmem, writereg_exmem,
                             reg_write_memwb, writereg_memwb, hist_valid_q, hist_reg_q);
            fwd_b  = fwd_sel(rt_ex, reg_write_exmem, writereg_exmem,
                             reg_write_memwb, writereg_memwb, hist_valid_q, hist_reg_q);
            fwd_sm = mem_write_exmem && reg_write_memwb && (writereg_memwb != '0)
                     && (writereg_memwb == rt_exmem);
        end
        interlock_hit = !forwarding && (id_hit(reg_write_ex,    writereg_ex,    rs_id, rt_id) ||
                                        id_hit(reg_write_exmem, writereg_exmem, rs_id, rt_id) ||
                                        id_hit(reg_write_memwb, writereg_memwb, rs_id, rt_id));
        load_hazard = mem_read_ex && (writereg_ex != '0)
                      && ((writereg_ex == rs_id) || (writereg_ex == rt_id));
    end

    // Load-use FSM: the detection cycle is the first bubble, STALL supplies the rest.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        lu_stall = 1'b0;
        if (!forwarding) begin
            state_d = IDLE;
            rem_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_hazard) begin
                        lu_stall = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = STALL;
                            rem_d   = REM_INIT;
                        end
                    end
                end
                STALL: begin
                    lu_stall = 1'b1;
                    rem_d    = rem_q - 2'd1;
                    if (rem_q <= 2'd1) begin
                        state_d = IDLE;
                        rem_d   = 2'd0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rem_d   = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        stall_raw = interlock_hit || lu_stall;
        fwd_any   = (fwd_a != 2'b00) || (fwd_b != 2'b00) || fwd_sm;

        hist_valid_d = 1'b0;
        hist_reg_d   = hist_reg_q;
        hist_data_d  = hist_data_q;
        if (reg_write_memwb && writereg_memwb != '0) begin
            hist_valid_d = 1'b1;
            hist_reg_d   = writereg_memwb;
            hist_data_d  = wb_data_memwb;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_raw && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
        fwd_cnt_d = fwd_cnt_q;
        if (fwd_any && fwd_cnt_q != '1) fwd_cnt_d = fwd_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rem_q        <= 2'd0;
            hist_valid_q <= 1'b0;
            hist_reg_q   <= '0;
            hist_data_q  <= '0;
            stall_cnt_q  <= '0;
            fwd_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            hist_valid_q <= hist_valid_d;
            hist_reg_q   <= hist_reg_d;
            hist_data_q  <= hist_data_d;
            stall_cnt_q  <= stall_cnt_d;
            fwd_cnt_q    <= fwd_cnt_d;
        end
    end

    // Combinational outputs are held low for as long as reset is asserted.
    always_comb begin
        forwardAE   = rst_n ? fwd_a : 2'b00;
        forwardBE   = rst_n ? fwd_b : 2'b00;
        forwardSM   = rst_n && fwd_sm;
        stall_if    = rst_n && stall_raw;
        stall_id    = rst_n && stall_raw;
        flush_ex    = rst_n && stall_raw;
        hist_data   = rst_n ? hist_data_q : '0;
        stall_count = rst_n ? stall_cnt_q : '0;
        fwd_count   = rst_n ? fwd_cnt_q : '0;
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit (3-cycle load stall, 3-bit counters so saturation is reachable).
module tb_fwd_hazard_unit;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              forwarding;
    logic [ADDR_W-1:0] rs_id, rt_id, rs_ex, rt_ex;
    logic              mem_read_ex, reg_write_ex;
    logic [ADDR_W-1:0] writereg_ex;
    logic              reg_write_exmem;
    logic [ADDR_W-1:0] writereg_exmem;
    logic              mem_write_exmem;
    logic [ADDR_W-1:0] rt_exmem;
    logic              reg_write_memwb;
    logic [ADDR_W-1:0] writereg_memwb;
    logic [DATA_W-1:0] wb_data_memwb;
    logic [1:0]        forwardAE, forwardBE;
    logic              forwardSM;
    logic [DATA_W-1:0] hist_data;
    logic              stall_if, stall_id, flush_ex;
    logic [CNT_W-1:0]  stall_count, fwd_count;

    int n_assert = 0;
    int n_fail   = 0;

    fwd_hazard_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOAD_STALL_CYCLES(3), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .forwarding(forwarding),
        .rs_id(rs_id), .rt_id(rt_id), .rs_ex(rs_ex), .rt_ex(rt_ex),
        .mem_read_ex(mem_read_ex), .reg_write_ex(reg_write_ex), .writereg_ex(writereg_ex),
        .reg_write_exmem(reg_write_exmem), .writereg_exmem(writereg_exmem),
        .mem_write_exmem(mem_write_exmem), .rt_exmem(rt_exmem),
        .reg_write_memwb(reg_write_memwb), .writereg_memwb(writereg_memwb),
        .wb_data_memwb(wb_data_memwb),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .forwardSM(forwardSM),
        .hist_data(hist_data),
        .stall_if(stall_if), .stall_id(stall_id), .flush_ex(flush_ex),
        .stall_count(stall_count), .fwd_count(fwd_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk({tag, "_if"},    {31'd0, stall_if}, {31'd0, exp});
        chk({tag, "_id"},    {31'd0, stall_id}, {31'd0, exp});
        chk({tag, "_flush"}, {31'd0, flush_ex}, {31'd0, exp});
    endtask

    task automatic clr();
        forwarding      = 1'b1;
        rs_id = '0; rt_id = '0; rs_ex = '0; rt_ex = '0;
        mem_read_ex     = 1'b0; reg_write_ex = 1'b0; writereg_ex = '0;
        reg_write_exmem = 1'b0; writereg_exmem = '0;
        mem_write_exmem = 1'b0; rt_exmem = '0;
        reg_write_memwb = 1'b0; writereg_memwb = '0; wb_data_memwb = '0;
    endtask

    task automatic cyc();
        @(negedge clk);
        clr();
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        reg_write_exmem = 1'b1; writereg_exmem = 5'd8; rs_ex = 5'd8;
        mem_read_ex = 1'b1; writereg_ex = 5'd4; rs_id = 5'd4;
        #1;
        chk("rst_fwdA", forwardAE, 2'b00);
        chk_stall("rst_stall", 1'b0);
        chk("rst_stall_cnt", stall_count, 0);
        chk("rst_fwd_cnt", fwd_count, 0);
        chk("rst_hist", hist_data, 0);

        cyc(); rst_n = 1'b1; #1;
        chk("idle_fwdA", forwardAE, 2'b00);
        chk_stall("idle_stall", 1'b0);

        // back-to-back ALU ops: EX/MEM wins over MEM/WB
        cyc();
        reg_write_exmem = 1'b1; writereg_exmem = 5'd8;
        reg_write_memwb = 1'b1; writereg_memwb = 5'd8; wb_data_memwb = 32'h11;
        rs_ex = 5'd8; rt_ex = 5'd8; #1;
        chk("b2b_fwdA", forwardAE, 2'b10);
        chk("b2b_fwdB", forwardBE, 2'b10);
        chk("b2b_fwd_cnt_before", fwd_count, 0);
        cyc(); #1;
        chk("b2b_fwd_cnt_after", fwd_count, 1);
        chk("b2b_hist_data", hist_data, 32'h11);

        // MEM/WB match on rs, r0 producer in EX/MEM ignored on rt
        cyc();
        reg_write_exmem = 1'b1; writereg_exmem = 5'd0;
        reg_write_memwb = 1'b1; writereg_memwb = 5'd7; wb_data_memwb = 32'h77;
        rs_ex = 5'd7; rt_ex = 5'd0; #1;
        chk("memwb_fwdA", forwardAE, 2'b01);
        chk("r0_fwdB", forwardBE, 2'b00);

        // history register: valid exactly one cycle after writeback
        cyc();
        reg_write_memwb = 1'b1; writereg_memwb = 5'd9; wb_data_memwb = 32'hDEADBEEF; #1;
        chk("hist_load_fwdA", forwardAE, 2'b00);
        chk("hist_load_fwdB", forwardBE, 2'b00);
        cyc(); rt_ex = 5'd9; #1;
        chk("hist_fwdB", forwardBE, 2'b11);
        chk("hist_fwdA", forwardAE, 2'b00);
        chk("hist_data", hist_data, 32'hDEADBEEF);
        cyc(); rt_ex = 5'd9; #1;
        chk("hist_expired_fwdB", forwardBE, 2'b00);
        chk("hist_fwd_cnt", fwd_count, 3);

        // store-data forwarding
        cyc();
        mem_write_exmem = 1'b1; rt_exmem = 5'd10;
        reg_write_memwb = 1'b1; writereg_memwb = 5'd10; wb_data_memwb = 32'hA; #1;
        chk("sm_hit", forwardSM, 1'b1);
        chk("sm_fwdA", forwardAE, 2'b00);
        cyc();
        mem_write_exmem = 1'b1; rt_exmem = 5'd0;
        reg_write_memwb = 1'b1; writereg_memwb = 5'd0; #1;
        chk("sm_r0", forwardSM, 1'b0);
        chk("sm_fwd_cnt", fwd_count, 4);

        // interlock mode
        cyc(); forwarding = 1'b0;
        reg_write_exmem = 1'b1; writereg_exmem = 5'd5; rt_id = 5'd5;
        rs_ex = 5'd5; rt_ex = 5'd5; #1;
        chk_stall("il_exmem", 1'b1);
        chk("il_fwdA", forwardAE, 2'b00);
        chk("il_fwdB", forwardBE, 2'b00);
        cyc(); forwarding = 1'b0;
        reg_write_memwb = 1'b1; writereg_memwb = 5'd5; wb_data_memwb = 32'h55; rt_id = 5'd5;
        mem_write_exmem = 1'b1; rt_exmem = 5'd5; #1;
        chk_stall("il_memwb", 1'b1);
        chk("il_sm", forwardSM, 1'b0);
        cyc(); forwarding = 1'b0; rt_id = 5'd5; #1;
        chk_stall("il_clear", 1'b0);
        chk("il_stall_cnt", stall_count, 2);
        chk("il_fwd_cnt", fwd_count, 4);
        cyc(); forwarding = 1'b0; reg_write_ex = 1'b1; writereg_ex = 5'd6; rs_id = 5'd6; #1;
        chk_stall("il_ex", 1'b1);
        cyc(); #1;
        chk_stall("il_ex_clear", 1'b0);
        chk("il_ex_stall_cnt", stall_count, 3);

        // load-use hazard, three bubbles
        cyc(); mem_read_ex = 1'b1; reg_write_ex = 1'b1; writereg_ex = 5'd4; rs_id = 5'd4; #1;
        chk_stall("lu_detect", 1'b1);
        cyc(); rs_id = 5'd4; #1;
        chk_stall("lu_bubble2", 1'b1);
        cyc(); rs_id = 5'd4; #1;
        chk_stall("lu_bubble3", 1'b1);
        cyc(); rs_id = 5'd4; #1;
        chk_stall("lu_done", 1'b0);
        chk("lu_stall_cnt", stall_count, 6);

        // reset in the middle of a load stall
        cyc(); mem_read_ex = 1'b1; reg_write_ex = 1'b1; writereg_ex = 5'd4; rt_id = 5'd4; #1;
        chk_stall("rst_lu_detect", 1'b1);
        cyc(); reg_write_exmem = 1'b1; writereg_exmem = 5'd8; rs_ex = 5'd8; #1;
        chk_stall("rst_lu_in_stall", 1'b1);
        rst_n = 1'b0; #1;
        chk_stall("rst_mid_stall", 1'b0);
        chk("rst_mid_fwdA", forwardAE, 2'b00);
        chk("rst_mid_stall_cnt", stall_count, 0);
        chk("rst_mid_fwd_cnt", fwd_count, 0);
        chk("rst_mid_hist", hist_data, 0);
        cyc(); rst_n = 1'b1; rt_ex = 5'd8; #1;
        chk_stall("post_rst_idle", 1'b0);
        chk("post_rst_fwdB", forwardBE, 2'b00);
        chk("post_rst_stall_cnt", stall_count, 0);

        // counter saturation
        for (int i = 0; i < 9; i++) begin
            cyc(); reg_write_exmem = 1'b1; writereg_exmem = 5'd8; rs_ex = 5'd8; #1;
        end
        cyc(); #1;
        chk("sat_fwd_cnt", fwd_count, 7);
        for (int i = 0; i < 9; i++) begin
            cyc(); forwarding = 1'b0; reg_write_exmem = 1'b1; writereg_exmem = 5'd8; rt_id = 5'd8; #1;
        end
        cyc(); #1;
        chk("sat_stall_cnt", stall_count, 7);
        chk("sat_fwd_hold", fwd_count, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and hazard controller for the 5-stage MIPS pipeline. It generalises the store-data forwarding check into the following:
- full EX-operand forwarding (A/B) from EX/MEM, MEM/WB and a one-entry post-writeback history register;
- MEM-stage store-data forwarding;
- a multi-cycle load-use stall FSM;
- saturating stall/forward event counters.

It sits beside the ID/EX/MEM/WB pipeline registers and drives the ALU operand muxes, the store-data mux and the IF/ID stall and ID/EX flush controls.

Parameters:
- ADDR_W, 5: register-address width.
- DATA_W, 32: datapath width of the writeback value captured in the history register.
- LOAD_STALL_CYCLES, 1: bubbles inserted per load-use hazard. Legal range 1..3.
- CNT_W, 16: width of the event counters.

Ports:
- clk  in  1  pipeline clock. Single clock.
- rst_n  in  1  asynchronous, active-low reset.
- forwarding  in  1  1 = forwarding mode; 0 = interlock-only mode.
- rs_id, rt_id  in  ADDR_W  source registers of the instruction in ID.
- rs_ex, rt_ex  in  ADDR_W  source registers of the instruction in EX.
- mem_read_ex  in  1  the instruction in EX is a load.
- reg_write_ex  in  1  the instruction in EX writes a register.
- writereg_ex  in  ADDR_W  destination register of the instruction in EX.
- reg_write_exmem  in  1  EX/MEM writes a register.
- writereg_exmem  in  ADDR_W  EX/MEM destination register.
- mem_write_exmem  in  1  EX/MEM holds a store.
- rt_exmem  in  ADDR_W  store-data source register of the store in MEM.
- reg_write_memwb  in  1  MEM/WB writes a register.
- writereg_memwb  in  ADDR_W  MEM/WB destination register.
- wb_data_memwb  in  DATA_W  writeback value.
- forwardAE, forwardBE  out  2  EX operand select: 00 = register file, 10 = EX/MEM, 01 = MEM/WB, 11 = history.
- forwardSM  out  1  1 = store data taken from wb_data_memwb.
- hist_data  out  DATA_W  history register value.
- stall_if, stall_id, flush_ex  out  1  pipeline control.
- stall_count, fwd_count  out  CNT_W  event counters.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM returns to IDLE; hist_valid, hist_reg and hist_data clear; both counters clear.
  - While rst_n is low, every output is forced to 0, including the combinational ones.
- Register 0 is never a forwarding or hazard source. Any match where the producer register is 0 is ignored.
- Operand forwarding (forwarding=1), evaluated per operand X in {rs_ex → AE, rt_ex → BE}, highest priority first:
  - EX/MEM match (reg_write_exmem and writereg_exmem == X) → 10.
  - Else MEM/WB match (reg_write_memwb and writereg_memwb == X) → 01.
  - Else history match (hist_valid and hist_reg == X) → 11.
  - Else 00.
- History register:
  - On each clk edge where reg_write_memwb=1 and writereg_memwb≠0: capture hist_reg ← writereg_memwb, hist_data ← wb_data_memwb, hist_valid ← 1.
  - Otherwise hist_valid ← 0. The entry is valid for exactly one cycle.
- Store-data forwarding: forwardSM = forwarding & mem_write_exmem & reg_write_memwb & (writereg_memwb≠0) & (writereg_memwb == rt_exmem).
- forwarding=0 (interlock mode):
  - forwardAE, forwardBE and forwardSM are all 0.
  - Any ID source (rs_id/rt_id) matching a nonzero writing destination in EX, EX/MEM or MEM/WB asserts stall_if, stall_id and flush_ex combinationally, in that cycle.
  - The load-use FSM is bypassed. The interlock repeats each cycle until no match remains.
- Load-use FSM (forwarding=1), states IDLE and STALL, with a remaining-cycle counter rem:
  - Detection in IDLE: mem_read_ex & (writereg_ex≠0) & (writereg_ex == rs_id or writereg_ex == rt_id).
  - On detection, stall_if, stall_id and flush_ex assert combinationally in the same cycle.
  - If LOAD_STALL_CYCLES == 1, the FSM stays in IDLE.
  - If LOAD_STALL_CYCLES > 1, the FSM moves to STALL with rem ← LOAD_STALL_CYCLES−1.
  - In STALL, all three controls assert every cycle and rem decrements. When rem == 1, the next state is IDLE.
  - Detection inputs are ignored while in STALL.
  - Total bubbles per hazard = LOAD_STALL_CYCLES exactly.
- Counters:
  - stall_count increments on every clk edge where stall_id=1.
  - fwd_count increments on every edge where any of forwardAE≠00, forwardBE≠00 or forwardSM=1.
  - Both saturate at all-ones and never wrap.
- Mode switch: a change of forwarding mid-stall takes effect next cycle. If forwarding drops to 0 while in STALL, the FSM returns to IDLE and interlock rules apply.

Test Plan:
- Back-to-back ALU ops: EX/MEM writes r8, rs_ex=8, rt_ex=8, MEM/WB also writes r8 → forwardAE=forwardBE=10; fwd_count +1.
- MEM/WB writes r9 with data 0xDEADBEEF, next cycle rt_ex=9 and no other match → forwardBE=11, hist_data=0xDEADBEEF; the cycle after → 00.
- Store in MEM with rt_exmem=10, MEM/WB writes r10 → forwardSM=1. Same case with writereg_memwb=0 → forwardSM=0.
- LOAD_STALL_CYCLES=3: load to r4 in EX, rs_id=4 → stall_if/stall_id/flush_ex high for exactly 3 cycles; stall_count=3.
- forwarding=0: EX/MEM writes r5, rt_id=5 → stall asserted and all forward selects 00; stall deasserts once r5 has left MEM/WB.
- rst_n pulsed low during STALL → all outputs 0 immediately; after release, state IDLE, counters 0, hist_valid 0.
